// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO: one bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hilo_rd_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_out_q, dbz_out_d;

    logic                 is_div_s;
    logic                 is_signed_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_trial_s;
    logic [2*WIDTH-1:0]   prod_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Datapath helpers: one multiply step, one restoring-divide trial, signed product
    always_comb begin
        is_div_s    = op_q[1];
        is_signed_s = ~op_q[0];
        sign_a_s    = is_signed_s & a_q[WIDTH-1];
        sign_b_s    = is_signed_s & b_q[WIDTH-1];
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
        div_trial_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_q};
        prod_s      = qsign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

    // Next-state and result computation
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush) begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                    if (start) begin
                        op_d    = op;
                        a_d     = op_a;
                        b_d     = op_b;
                        state_d = PREP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                qsign_d = sign_a_s ^ sign_b_s;
                rsign_d = sign_a_s;
                cnt_d   = {CW{1'b0}};
                // Divide keeps |divisor| in mag and |dividend| in the low half; multiply the reverse.
                mag_d   = is_div_s ? magnitude(b_q, sign_b_s) : magnitude(a_q, sign_a_s);
                acc_d   = {{WIDTH{1'b0}}, is_div_s ? magnitude(a_q, sign_a_s) : magnitude(b_q, sign_b_s)};
                if (is_div_s && (b_q == {WIDTH{1'b0}})) begin
                    dbz_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    dbz_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_s) begin
                    acc_d = div_trial_s[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                               : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIN : CALC;
            end
            FIN: begin
                if (dbz_q) begin
                    lo_d = {WIDTH{1'b1}};
                    hi_d = a_q;
                end else if (is_div_s) begin
                    lo_d = magnitude(acc_q[WIDTH-1:0], qsign_q);
                    hi_d = magnitude(acc_q[2*WIDTH-1:WIDTH], rsign_q);
                end else begin
                    lo_d = prod_s[WIDTH-1:0];
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                end
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A flush abandons any in-flight op without touching HI/LO.
        if (flush && (state_q != IDLE)) begin
            state_d   = IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            mag_q     <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            cnt_q     <= {CW{1'b0}};
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != IDLE);
    assign stall_req   = busy & (hilo_rd_req | start | hi_we | lo_we);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed and random ops against a
// plain-arithmetic reference, plus flush, stall, MTHI/MTLO and reset scenarios.
module tb_mdu_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start, flush, hilo_rd_req, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  op_a, op_b, wdata;
    logic [W-1:0]  hi, lo;
    logic          busy, stall_req, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .flush(flush), .hilo_rd_req(hilo_rd_req), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req),
        .done(done), .div_by_zero(div_by_zero)
    );

    // Reference: returns {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dbz = 1'b0;
        res = 64'd0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin dbz = 1'b1; res = {a, 32'hFFFF_FFFF}; end
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 32'd0) begin dbz = 1'b1; res = {a, 32'hFFFF_FFFF}; end
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Issue one op and wait (bounded) for done; returns observations only
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output logic got_done, output logic overlap);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0; got_done = 1'b0; overlap = 1'b0;
        while (!got_done && lat < 200) begin
            if (busy && (done || div_by_zero)) overlap = 1'b1;
            if (done) got_done = 1'b1;
            else begin
                if (busy) bcnt++;
                @(posedge clk); lat++; @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flush = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        hilo_rd_req = 1'b0; op = 2'd0; op_a = 32'd5; op_b = 32'd3; wdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dbz=%b, want all zero", hi, lo, busy, done, div_by_zero);
        end
        rst = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    typedef struct { logic [1:0] o; logic [31:0] a, b, ehi, elo; logic edbz; } vec_t;

    task automatic test_directed();
        vec_t v [6];
        int lat, bcnt; logic gd, ov;
        v[0] = '{2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        v[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        v[2] = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        v[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        v[5] = '{2'd3, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].o, v[i].a, v[i].b, lat, bcnt, gd, ov);
            checks++;
            if (!gd || hi !== v[i].ehi || lo !== v[i].elo || div_by_zero !== v[i].edbz) begin
                errors++;
                $display("FAIL directed[%0d]: done=%b hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                         i, gd, hi, lo, div_by_zero, v[i].ehi, v[i].elo, v[i].edbz);
            end
            checks++;
            if (lat != (v[i].edbz ? 2 : W + 2) || bcnt != (v[i].edbz ? 2 : W + 2) || ov) begin
                errors++;
                $display("FAIL directed_timing[%0d]: lat=%0d busy_cycles=%0d overlap=%b, want %0d/%0d/0",
                         i, lat, bcnt, ov, v[i].edbz ? 2 : W + 2, v[i].edbz ? 2 : W + 2);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse[%0d]: done=%b busy=%b, want 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] o; logic [31:0] a, b; logic [63:0] exp; logic edbz;
        int lat, bcnt; logic gd, ov;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            exp = ref_model(o, a, b, edbz);
            run_op(o, a, b, lat, bcnt, gd, ov);
            checks++;
            if (!gd || {hi, lo} !== exp || div_by_zero !== edbz || lat != (edbz ? 2 : W + 2) || ov) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: done=%b hi=%h lo=%h dbz=%b lat=%0d, want hi=%h lo=%h dbz=%b lat=%0d",
                         i, o, a, b, gd, hi, lo, div_by_zero, lat, exp[63:32], exp[31:0], edbz, edbz ? 2 : W + 2);
            end
        end
    endtask

    task automatic test_flush();
        int lat, bcnt; logic gd, ov; logic seen;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_we = 1'b0;
        start = 1'b1; op = 2'd0; op_a = 32'd6; op_b = 32'd7;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: busy=%b, want 0", busy);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || div_by_zero) seen = 1'b1;
        end
        checks++;
        if (seen || hi !== 32'h11 || lo !== 32'h22) begin
            errors++;
            $display("FAIL flush_result: done_seen=%b hi=%h lo=%h, want 0/11/22", seen, hi, lo);
        end
        // flush in IDLE drops start and MTLO
        start = 1'b1; lo_we = 1'b1; wdata = 32'h99; flush = 1'b1;
        @(negedge clk); start = 1'b0; lo_we = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || lo !== 32'h22) begin
            errors++;
            $display("FAIL flush_idle: busy=%b lo=%h, want 0/22", busy, lo);
        end
        run_op(2'd0, 32'd6, 32'd7, lat, bcnt, gd, ov);
        checks++;
        if (!gd || lo !== 32'd42 || hi !== 32'd0) begin
            errors++;
            $display("FAIL flush_rerun: done=%b hi=%h lo=%h, want 1/0/2a", gd, hi, lo);
        end
    endtask

    task automatic test_stall();
        int n; logic bad_stall; logic [31:0] lo_before;
        @(negedge clk);
        start = 1'b1; op = 2'd1; op_a = 32'd1000; op_b = 32'd3; hilo_rd_req = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        n = 0; bad_stall = 1'b0;
        while (busy && n < 200) begin
            if (stall_req !== 1'b1) bad_stall = 1'b1;
            if (n == 5) begin
                lo_before = lo; lo_we = 1'b1; wdata = 32'h55;
                #1;
                checks++;
                if (stall_req !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_mtlo: stall_req=%b, want 1", stall_req);
                end
            end
            if (n == 6) begin
                lo_we = 1'b0;
                checks++;
                if (lo !== lo_before) begin
                    errors++;
                    $display("FAIL mtlo_busy: lo=%h, want %h", lo, lo_before);
                end
            end
            start = (n == 10);
            op = 2'd3; op_a = 32'd9; op_b = 32'd0;
            @(negedge clk); n++;
        end
        start = 1'b0;
        checks++;
        if (bad_stall || n != W + 2) begin
            errors++;
            $display("FAIL stall_busy: bad_stall=%b busy_cycles=%0d, want 0/%0d", bad_stall, n, W + 2);
        end
        checks++;
        if (done !== 1'b1 || stall_req !== 1'b0 || lo !== 32'd3000 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b stall=%b hi=%h lo=%h dbz=%b, want 1/0/0/bb8/0",
                     done, stall_req, hi, lo, div_by_zero);
        end
        hilo_rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: busy=%b, want 0", busy);
        end
        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk); lo_we = 1'b0;
        checks++;
        if (lo !== 32'h55) begin
            errors++;
            $display("FAIL mtlo_idle: lo=%h, want 55", lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        // start together with MTHI: write lands now, result overwrites it later
        @(negedge clk);
        start = 1'b1; op = 2'd3; op_a = 32'd100; op_b = 32'd7; hi_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk);
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        checks++;
        if (hi !== 32'hABCD || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_mthi: hi=%h busy=%b, want abcd/1", hi, busy);
        end
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!done || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL start_mthi_result: done=%b hi=%h lo=%h, want 1/2/e", done, hi, lo);
        end
        // reset in the middle of an op clears everything
        start = 1'b1; op = 2'd0; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: busy=%b hi=%h lo=%h done=%b, want 0/0/0/0", busy, hi, lo, done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
